// File: rtl/face_detection_cu_if.sv
// rtl/face_detection_cu_if.sv - CU-side handshake bundle between the face-detection control unit and its datapath
interface face_detection_cu_if;
  logic write_next_frame_dp;
  logic new_image_ready_dp;
  logic select_window_start_ws;
  logic break_ws;
  logic done_ws;
  logic windows_out_ws;
  logic rescaler_start_wr;
  logic busy_wr;
  logic classifier_start_c;
  logic final_judge_c;
  logic classifier_done_c;
  logic write_result_start_dp;

  modport master (
    output write_next_frame_dp, select_window_start_ws, break_ws,
           rescaler_start_wr, classifier_start_c, write_result_start_dp,
    input  new_image_ready_dp, done_ws, windows_out_ws, busy_wr,
           final_judge_c, classifier_done_c
  );

  modport slave (
    input  write_next_frame_dp, select_window_start_ws, break_ws,
           rescaler_start_wr, classifier_start_c, write_result_start_dp,
    output new_image_ready_dp, done_ws, windows_out_ws, busy_wr,
           final_judge_c, classifier_done_c
  );
endinterface

// File: rtl/face_detection_cu.sv
// rtl/face_detection_cu.sv - frame sequencer for the face-detection datapath
// Walks imager -> window selector -> rescaler -> classifier -> result writer, one frame at a time.
module face_detection_cu #(
  parameter int MAX_FACES = 8,
  parameter int TIMEOUT_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 abort,
  face_detection_cu_if.master  dp,
  output logic                 frame_done,
  output logic [7:0]           face_count,
  output logic [CNT_W-1:0]     window_count,
  output logic                 error
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_IMG, S_SEL, S_WAIT_WIN, S_RS_START, S_RS_ARM,
    S_RS_WAIT, S_CL_START, S_CL_WAIT, S_WR, S_BRK, S_WAIT_DONE, S_END
  } state_t;

  localparam logic [7:0] MAX_FACES_C = 8'(MAX_FACES);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic [1:0]           arm_q, arm_d;
  logic                 abort_q, abort_d;
  logic [7:0]           face_q, face_d;
  logic [CNT_W-1:0]     win_q, win_d;
  logic                 err_q, err_d;
  logic                 wnf_q, wnf_d, sel_q, sel_d, brk_q, brk_d;
  logic                 rs_q, rs_d, cl_q, cl_d, wr_q, wr_d, fd_q, fd_d;
  logic                 in_window, abort_pend, wait_state, wd_expire;

  always_comb begin
    in_window  = state_q inside {S_RS_START, S_RS_ARM, S_RS_WAIT,
                                 S_CL_START, S_CL_WAIT, S_WR};
    abort_pend = abort_q | (abort & in_window);
    wait_state = state_q inside {S_WAIT_IMG, S_WAIT_WIN, S_RS_WAIT,
                                 S_CL_WAIT, S_WAIT_DONE};
    wd_inc     = wd_q + TIMEOUT_W'(1);
    // A wait expires on the cycle its counter would reach all-ones.
    wd_expire  = wait_state && (wd_inc == '1);
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    abort_d = (state_q == S_END) ? 1'b0 : abort_pend;
    face_d  = face_q;
    win_d   = win_q;
    err_d   = err_q;
    wnf_d   = 1'b0;
    sel_d   = 1'b0;
    brk_d   = 1'b0;
    rs_d    = 1'b0;
    cl_d    = 1'b0;
    wr_d    = 1'b0;
    fd_d    = 1'b0;

    case (state_q)
      S_IDLE:     if (enable) state_d = S_REQ;
      S_REQ: begin
        wnf_d   = 1'b1;
        face_d  = '0;
        win_d   = '0;
        state_d = S_WAIT_IMG;
      end
      S_WAIT_IMG: if (dp.new_image_ready_dp) state_d = S_SEL;
      S_SEL: begin
        if (abort) begin
          state_d = S_BRK;
        end else begin
          sel_d   = 1'b1;
          state_d = S_WAIT_WIN;
        end
      end
      S_WAIT_WIN: begin
        if (dp.done_ws)             state_d = S_END;
        else if (abort)             state_d = S_BRK;
        else if (dp.windows_out_ws) state_d = S_RS_START;
      end
      S_RS_START: begin
        rs_d    = 1'b1;
        state_d = S_RS_ARM;
      end
      // A rescaler that never raises busy within four cycles is taken as already done.
      S_RS_ARM: begin
        if (dp.busy_wr)          state_d = S_RS_WAIT;
        else if (arm_q == 2'd3)  state_d = S_CL_START;
        else                     arm_d   = arm_q + 2'd1;
      end
      S_RS_WAIT:  if (!dp.busy_wr) state_d = S_CL_START;
      S_CL_START: begin
        cl_d    = 1'b1;
        state_d = S_CL_WAIT;
      end
      S_CL_WAIT: begin
        if (dp.classifier_done_c) begin
          if (win_q != '1) win_d = win_q + CNT_W'(1);
          if (dp.final_judge_c) state_d = S_WR;
          else if (abort_pend)  state_d = S_BRK;
          else                  state_d = S_SEL;
        end
      end
      S_WR: begin
        wr_d   = 1'b1;
        face_d = face_q + 8'd1;
        if ((face_q + 8'd1) == MAX_FACES_C || abort_pend) state_d = S_BRK;
        else                                              state_d = S_SEL;
      end
      S_BRK: begin
        brk_d   = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (dp.done_ws) state_d = S_END;
      S_END: begin
        fd_d    = 1'b1;
        state_d = enable ? S_REQ : S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase

    if (wd_expire && state_d == state_q) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      fd_d    = 1'b1;
    end

    wd_d = (state_d != state_q || !wait_state) ? '0 : wd_inc;
    if (state_d != state_q) arm_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      arm_q   <= '0;
      abort_q <= 1'b0;
      face_q  <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
      wnf_q   <= 1'b0;
      sel_q   <= 1'b0;
      brk_q   <= 1'b0;
      rs_q    <= 1'b0;
      cl_q    <= 1'b0;
      wr_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      arm_q   <= arm_d;
      abort_q <= abort_d;
      face_q  <= face_d;
      win_q   <= win_d;
      err_q   <= err_d;
      wnf_q   <= wnf_d;
      sel_q   <= sel_d;
      brk_q   <= brk_d;
      rs_q    <= rs_d;
      cl_q    <= cl_d;
      wr_q    <= wr_d;
      fd_q    <= fd_d;
    end
  end

  assign dp.write_next_frame_dp    = wnf_q;
  assign dp.select_window_start_ws = sel_q;
  assign dp.break_ws               = brk_q;
  assign dp.rescaler_start_wr      = rs_q;
  assign dp.classifier_start_c     = cl_q;
  assign dp.write_result_start_dp  = wr_q;
  assign frame_done                = fd_q;
  assign face_count                = face_q;
  assign window_count              = win_q;
  assign error                     = err_q;

endmodule
